// File: rtl/writeback_stage.sv
// Write-back stage: buffers memory-stage results in a small FIFO, drains one per
// cycle into the register-file write port, and reports pending writes for decode.
module writeback_stage #(
   parameter int DEPTH = 2,
   parameter int AW    = 4,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_reg_write,
   input  logic          in_mem_to_reg,
   input  logic [AW-1:0] in_rd,
   input  logic [DW-1:0] in_alu_data,
   input  logic [DW-1:0] in_mem_data,
   input  logic          wb_hold,
   output logic          r_write,
   output logic [AW-1:0] rd,
   output logic [DW-1:0] w_data,
   input  logic [AW-1:0] rs,
   input  logic [AW-1:0] rt,
   output logic          hazard_a,
   output logic          hazard_b,
   output logic [DW-1:0] fwd_a_data,
   output logic [DW-1:0] fwd_b_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0] rd_mem_r   [DEPTH];
   logic [DW-1:0] data_mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;

   logic          r_write_r;
   logic [AW-1:0] rd_r;
   logic [DW-1:0] w_data_r;

   logic          in_ready_s;
   logic          push_s;
   logic          pop_s;
   logic [DW-1:0] in_data_s;
   logic          hazard_a_s;
   logic          hazard_b_s;
   logic [DW-1:0] fwd_a_s;
   logic [DW-1:0] fwd_b_s;

   // Handshake and push/pop decisions; in_ready depends on the count alone.
   always_comb begin
      in_ready_s = (count_r < DEPTH_C);
      push_s     = in_valid & in_ready_s & in_reg_write;
      pop_s      = ~wb_hold & (count_r != {CW{1'b0}});
      if (in_mem_to_reg) begin
         in_data_s = in_mem_data;
      end else begin
         in_data_s = in_alu_data;
      end
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_mem_r[i]   <= '0;
            data_mem_r[i] <= '0;
         end
      end else begin
         if (push_s) begin
            rd_mem_r[wr_ptr_r]   <= in_rd;
            data_mem_r[wr_ptr_r] <= in_data_s;
            wr_ptr_r             <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Register-file write port; address and data hold their last values when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write_r <= 1'b0;
         rd_r      <= '0;
         w_data_r  <= '0;
      end else if (pop_s) begin
         r_write_r <= 1'b1;
         rd_r      <= rd_mem_r[rd_ptr_r];
         w_data_r  <= data_mem_r[rd_ptr_r];
      end else begin
         r_write_r <= 1'b0;
      end
   end

   // Hazard/forward lookup: output register first, then FIFO oldest to youngest so the youngest wins.
   always_comb begin
      logic [PW-1:0] idx_v;
      logic          live_v;
      logic          hit_a_v;
      logic          hit_b_v;
      idx_v      = '0;
      live_v     = 1'b0;
      hit_a_v    = r_write_r & (rd_r == rs);
      hit_b_v    = r_write_r & (rd_r == rt);
      hazard_a_s = hit_a_v;
      hazard_b_s = hit_b_v;
      fwd_a_s    = hit_a_v ? w_data_r : {DW{1'b0}};
      fwd_b_s    = hit_b_v ? w_data_r : {DW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         idx_v      = rd_ptr_r + PW'(i);
         live_v     = (CW'(i) < count_r);
         hit_a_v    = live_v & (rd_mem_r[idx_v] == rs);
         hit_b_v    = live_v & (rd_mem_r[idx_v] == rt);
         hazard_a_s = hazard_a_s | hit_a_v;
         hazard_b_s = hazard_b_s | hit_b_v;
         fwd_a_s    = hit_a_v ? data_mem_r[idx_v] : fwd_a_s;
         fwd_b_s    = hit_b_v ? data_mem_r[idx_v] : fwd_b_s;
      end
   end

   assign in_ready   = in_ready_s;
   assign r_write    = r_write_r;
   assign rd         = rd_r;
   assign w_data     = w_data_r;
   assign hazard_a   = hazard_a_s;
   assign hazard_b   = hazard_b_s;
   assign fwd_a_data = fwd_a_s;
   assign fwd_b_data = fwd_b_s;

endmodule
